// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes,
// opcode class headers, exact opcodes and trap cause codes.
package multicycle_control_fsm_pkg;

  // Control-state encodings (4 bits; 13..15 are unused and trap)
  localparam logic [3:0] S_IF        = 4'd0;
  localparam logic [3:0] S_RF        = 4'd1;
  localparam logic [3:0] S_IMM_INJ3  = 4'd2;
  localparam logic [3:0] S_ALU_R3    = 4'd3;
  localparam logic [3:0] S_ALU_RI3   = 4'd4;
  localparam logic [3:0] S_ALU4      = 4'd5;
  localparam logic [3:0] S_BRANCH3   = 4'd6;
  localparam logic [3:0] S_MEM_REF3  = 4'd7;
  localparam logic [3:0] S_LOAD4     = 4'd8;
  localparam logic [3:0] S_STORE4    = 4'd9;
  localparam logic [3:0] S_LOAD5     = 4'd10;
  localparam logic [3:0] S_JUMP3     = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  // Exact opcodes within the 6-bit header view
  localparam logic [5:0] OP_LD   = 6'b101000;
  localparam logic [5:0] OP_STR  = 6'b101001;
  localparam logic [5:0] OP_JUMP = 6'b110000;
  localparam logic [5:0] OP_LDI  = 6'b110001;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Instruction class produced by the RF-stage classifier
  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_RI,
    CLS_BRANCH,
    CLS_MEM_REF,
    CLS_JUMP,
    CLS_LDI,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Saturating wait-state counter for data-memory accesses. Flags when the
// count has reached the configured timeout.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [TMO_W-1:0] cnt;

  // Count not-ready cycles; clear has priority, count saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {TMO_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: IF -> RF -> class-specific states, with
// memory ready handshakes, bounded data-memory wait and a sticky trap.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic [3:0]          state,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                retire,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  logic [3:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [5:0] op_hdr;
  op_class_t  op_cls;
  logic       in_wait, tmr_clr, tmr_en, tmr_timeout;

  // Class headers live in the opcode MSBs
  assign op_hdr = opcode[OPCODE_W-1 -: 6];

  // Classify the opcode header into an instruction class
  always_comb begin
    op_cls = CLS_ILLEGAL;
    casez (op_hdr)
      6'b00????: op_cls = CLS_ALU_R;
      6'b01????: op_cls = CLS_ALU_RI;
      6'b100???: op_cls = CLS_BRANCH;
      6'b101???: op_cls = CLS_MEM_REF;
      6'b110000: op_cls = CLS_JUMP;
      6'b110001: op_cls = CLS_LDI;
      default:   op_cls = CLS_ILLEGAL;
    endcase
  end

  // Counter runs only while stalled in a memory state; any other state or a
  // completed access clears it, so every entry to LOAD4/STORE4 starts at zero
  assign in_wait = (state_q == S_LOAD4) || (state_q == S_STORE4);
  assign tmr_en  = in_wait && !dmem_ready;
  assign tmr_clr = !in_wait || dmem_ready;

  multicycle_control_fsm_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .timeout (tmr_timeout)
  );

  // Next-state and trap-cause selection
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IF: if (imem_ready) state_d = S_RF;
      S_RF: begin
        case (op_cls)
          CLS_ALU_R:   state_d = S_ALU_R3;
          CLS_ALU_RI:  state_d = S_ALU_RI3;
          CLS_BRANCH:  state_d = S_BRANCH3;
          CLS_MEM_REF: state_d = S_MEM_REF3;
          CLS_JUMP:    state_d = S_JUMP3;
          CLS_LDI:     state_d = S_IMM_INJ3;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_ALU_R3, S_ALU_RI3: state_d = S_ALU4;
      S_MEM_REF3: begin
        if (op_hdr == OP_LD) begin
          state_d = S_LOAD4;
        end else if (op_hdr == OP_STR) begin
          state_d = S_STORE4;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_LOAD4, S_STORE4: begin
        // A ready on the timeout cycle still counts as a completed access
        if (dmem_ready) begin
          state_d = (state_q == S_LOAD4) ? S_LOAD5 : S_IF;
        end else if (tmr_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_ALU4, S_LOAD5, S_BRANCH3, S_JUMP3, S_IMM_INJ3: state_d = S_IF;
      S_TRAP: state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // State and cause registers; reset overrides everything including TRAP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Moore strobes (IF qualified by imem_ready, STORE4 exit by dmem_ready),
  // all held low while reset is asserted
  assign state      = state_q;
  assign ir_write   = !rst && (state_q == S_IF) && imem_ready;
  assign pc_write   = !rst && (((state_q == S_IF) && imem_ready) ||
                               (state_q == S_BRANCH3) || (state_q == S_JUMP3));
  assign reg_write  = !rst && ((state_q == S_ALU4) || (state_q == S_LOAD5) ||
                               (state_q == S_IMM_INJ3));
  assign mem_read   = !rst && (state_q == S_LOAD4);
  assign mem_write  = !rst && (state_q == S_STORE4);
  assign retire     = !rst && ((state_q == S_ALU4) || (state_q == S_LOAD5) ||
                               (state_q == S_BRANCH3) || (state_q == S_JUMP3) ||
                               (state_q == S_IMM_INJ3) ||
                               ((state_q == S_STORE4) && dmem_ready));
  assign trap       = !rst && (state_q == S_TRAP);
  assign trap_cause = (!rst && (state_q == S_TRAP)) ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: every driven cycle pushes the
// expected output vector, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic [3:0] state;
  logic       ir_write, pc_write, reg_write, mem_read, mem_write;
  logic       retire, trap;
  logic [1:0] trap_cause;

  int n_cmp = 0;
  int n_err = 0;
  string cur_tag = "reset";

  string       tag_q[$];
  logic [12:0] vec_q[$];

  multicycle_control_fsm #(
    .OPCODE_W    (6),
    .MEM_TIMEOUT (15),
    .TMO_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .state      (state),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d strobes=%b cause=%0d, want st=%0d strobes=%b cause=%0d",
               tag, obs[12:9], obs[8:2], obs[1:0], exp[12:9], exp[8:2], exp[1:0]);
    end
  endtask

  // Expected output vector {state, ir, pc, rw, mr, mw, retire, trap, cause}
  function automatic logic [12:0] expect_vec(input int st, input logic im, input logic dm,
                                             input logic r, input int cause);
    logic ir, pc, rw, mr, mw, ret, tr;
    logic [1:0] c;
    ir = 0; pc = 0; rw = 0; mr = 0; mw = 0; ret = 0; tr = 0; c = 0;
    if (!r) begin
      case (st)
        0:  begin ir = im; pc = im; end
        2:  begin rw = 1; ret = 1; end
        5:  begin rw = 1; ret = 1; end
        6:  begin pc = 1; ret = 1; end
        8:  mr = 1;
        9:  begin mw = 1; ret = dm; end
        10: begin rw = 1; ret = 1; end
        11: begin pc = 1; ret = 1; end
        12: begin tr = 1; c = 2'(cause); end
        default: ;
      endcase
    end
    return {4'(st), ir, pc, rw, mr, mw, ret, tr, c};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected during it
  task automatic cyc(input logic r, input logic im, input logic dm, input logic [5:0] op,
                     input int st, input int cause);
    @(posedge clk);
    #1;
    rst = r; imem_ready = im; dmem_ready = dm; opcode = op;
    tag_q.push_back(cur_tag);
    vec_q.push_back(expect_vec(st, im, dm, r, cause));
  endtask

  // Compare DUT outputs against the scoreboard away from the active edge
  always @(negedge clk) begin
    if (vec_q.size() > 0) begin
      chk(tag_q.pop_front(),
          {state, ir_write, pc_write, reg_write, mem_read, mem_write, retire, trap, trap_cause},
          vec_q.pop_front());
    end
  end

  initial begin
    logic [5:0] op;

    cur_tag = "reset";
    cyc(1, 1, 1, 6'b000011, 0, 0);
    cyc(1, 1, 1, 6'b000011, 0, 0);

    cur_tag = "alu_r";
    op = 6'b000011;
    cyc(0, 1, 1, op, 0, 0); cyc(0, 1, 1, op, 1, 0);
    cyc(0, 1, 1, op, 3, 0); cyc(0, 1, 1, op, 5, 0);

    cur_tag = "alu_ri";
    op = 6'b010110;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0);
    cyc(0, 1, 0, op, 4, 0); cyc(0, 1, 0, op, 5, 0);

    cur_tag = "ld_wait3";
    op = 6'b101000;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, op, 8, 0);
    cyc(0, 1, 1, op, 8, 0); cyc(0, 1, 0, op, 10, 0);

    cur_tag = "imem_stall_ldi";
    op = 6'b110001;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, op, 0, 0);
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 2, 0);

    cur_tag = "branch";
    op = 6'b100101;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 6, 0);

    cur_tag = "jump";
    op = 6'b110000;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 11, 0);

    cur_tag = "str_ready_at_limit";
    op = 6'b101001;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, op, 9, 0);
    cyc(0, 1, 1, op, 9, 0);

    cur_tag = "rst_mid_load4";
    op = 6'b101000;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, op, 8, 0);
    cyc(1, 1, 0, op, 8, 0);

    cur_tag = "ld_timeout";
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, op, 8, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, op, 12, 2);
    cyc(1, 1, 0, op, 12, 2);

    cur_tag = "str_timeout";
    op = 6'b101001;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, op, 9, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, op, 12, 2);
    cyc(1, 1, 0, op, 12, 2);

    cur_tag = "illegal_rf";
    op = 6'b111111;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, op, 12, 1);
    cyc(1, 1, 0, op, 12, 1);

    cur_tag = "illegal_memref";
    op = 6'b101011;
    cyc(0, 1, 0, op, 0, 0); cyc(0, 1, 0, op, 1, 0); cyc(0, 1, 0, op, 7, 0);
    cyc(0, 1, 0, op, 12, 1); cyc(0, 1, 1, op, 12, 1);
    cyc(1, 1, 0, op, 12, 1);

    cur_tag = "after_rst";
    cyc(0, 0, 0, op, 0, 0);
    cyc(0, 0, 0, op, 0, 0);

    for (int i = 0; i < 5; i++) begin
      if (vec_q.size() > 0) @(negedge clk);
    end
    #1;
    if (vec_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d entries left, want 0", vec_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
